uart_prog_loader: RTL and testbench

//  Boot-time program loader in front of the instruction ROM. Receives a framed program image

---
 rtl/uart_prog_loader_pkg.sv | 26 ++
 rtl/uart_prog_loader_if.sv | 27 ++
 rtl/uart_prog_loader_rx.sv | 94 +++++++++
 rtl/uart_prog_loader.sv | 174 +++++++++++++++++
 tb/tb_uart_prog_loader.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_prog_loader_pkg.sv
// Shared types for the UART program loader.
// Frame states, receiver states and frame constants.
package tinyriscv_loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int LOADER_CNT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERR
  } loader_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_BITS,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/uart_prog_loader_if.sv
// ROM write port driven by the program loader.
// Master issues word writes; slave returns the grant.
interface uart_prog_loader_if;

  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic        mem_gnt_i;

  modport master (
    output mem_req_o,
    output mem_we_o,
    output mem_addr_o,
    output mem_data_o,
    input  mem_gnt_i
  );

  modport slave (
    input  mem_req_o,
    input  mem_we_o,
    input  mem_addr_o,
    input  mem_data_o,
    output mem_gnt_i
  );

endinterface

// File: rtl/uart_prog_loader_rx.sv
// 8N1 UART byte receiver with input synchroniser.
// Emits a one-cycle rx_valid_o or frame_err_o per byte.
module uart_rx_byte
  import tinyriscv_loader_pkg::*;
#(
  parameter int DIV = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic       rx_valid_o,
  output logic [7:0] rx_data_o,
  output logic       frame_err_o
);

  localparam int CW = $clog2(DIV + 1);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(DIV - 1);

  // [1] is the synchronised line, [2] its previous value
  logic [2:0]    sync_q;
  rx_state_e     st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          rx_s, fall;

  assign rx_s        = sync_q[1];
  assign fall        = sync_q[2] & ~sync_q[1];
  assign rx_valid_o  = valid_q;
  assign frame_err_o = ferr_q;
  assign rx_data_o   = sh_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= 3'b111;
      st_q    <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[1:0], rx_i};
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    sh_d    = sh_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (st_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (fall) st_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF) begin
          cnt_d = '0;
          bit_d = '0;
          st_d  = rx_s ? RX_IDLE : RX_BITS;
        end
      end
      RX_BITS: begin
        if (cnt_q == FULL) begin
          cnt_d = '0;
          sh_d  = {rx_s, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) st_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL) begin
          cnt_d   = '0;
          st_d    = RX_IDLE;
          valid_d = rx_s;
          ferr_d  = ~rx_s;
        end
      end
    endcase
  end

endmodule

// File: rtl/uart_prog_loader.sv
// Boot-time loader: UART frame in, ROM word writes out.
// Holds the core while a frame is in progress.
module uart_prog_loader
  import tinyriscv_loader_pkg::*;
#(
  parameter int          CLK_FREQ  = 50_000_000,
  parameter int          BAUD      = 115_200,
  parameter logic [31:0] ROM_BASE  = 32'h0000_0000,
  parameter int          MAX_WORDS = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_en_i,
  input  logic                    uart_rx_i,
  uart_prog_loader_if.master      mem,
  output logic                    core_hold_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic [LOADER_CNT_W-1:0] word_cnt_o
);

  localparam logic [16:0] MAXW = 17'(MAX_WORDS);

  logic       rx_valid, frame_err;
  logic [7:0] rx_data;

  uart_rx_byte #(.DIV(CLK_FREQ / BAUD)) u_rx (
    .clk         (clk),
    .rst         (rst),
    .rx_i        (uart_rx_i),
    .rx_valid_o  (rx_valid),
    .rx_data_o   (rx_data),
    .frame_err_o (frame_err)
  );

  loader_state_e st_q, st_d;
  logic [15:0] len_q, len_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] word_q, word_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  csum_q, csum_d;
  logic        req_q, req_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        hold_q, hold_d;
  logic        abort;
  logic [15:0] n_new;

  assign mem.mem_req_o  = req_q;
  assign mem.mem_we_o   = req_q;
  assign mem.mem_addr_o = addr_q;
  assign mem.mem_data_o = word_q;
  assign core_hold_o    = hold_q;
  assign done_o         = done_q;
  assign err_o          = err_q;
  assign word_cnt_o     = cnt_q;
  assign n_new          = {rx_data, len_q[7:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q   <= S_IDLE;
      len_q  <= '0;
      cnt_q  <= '0;
      lane_q <= '0;
      word_q <= '0;
      addr_q <= '0;
      csum_q <= '0;
      req_q  <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      hold_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      len_q  <= len_d;
      cnt_q  <= cnt_d;
      lane_q <= lane_d;
      word_q <= word_d;
      addr_q <= addr_d;
      csum_q <= csum_d;
      req_q  <= req_d;
      done_q <= done_d;
      err_q  <= err_d;
      hold_q <= hold_d;
    end
  end

  // a byte arriving during WRITE has nowhere to go: treat as overrun
  assign abort = (st_q != S_IDLE) && (st_q != S_DONE)
              && (st_q != S_ERR)
              && (!load_en_i || frame_err
                  || (st_q == S_WRITE && rx_valid));

  always_comb begin
    st_d   = st_q;
    len_d  = len_q;
    cnt_d  = cnt_q;
    lane_d = lane_q;
    word_d = word_q;
    addr_d = addr_q;
    csum_d = csum_q;
    req_d  = req_q;
    done_d = done_q;
    err_d  = err_q;
    hold_d = hold_q;
    if (abort) begin
      st_d = S_ERR;
    end else begin
      unique case (st_q)
        S_IDLE: begin
          if (rx_valid && load_en_i && rx_data == SYNC_BYTE) begin
            st_d   = S_LEN0;
            done_d = 1'b0;
            err_d  = 1'b0;
            cnt_d  = '0;
            lane_d = '0;
            csum_d = '0;
            hold_d = 1'b1;
          end
        end
        S_LEN0: begin
          if (rx_valid) begin
            len_d[7:0] = rx_data;
            st_d       = S_LEN1;
          end
        end
        S_LEN1: begin
          if (rx_valid) begin
            len_d[15:8] = rx_data;
            if (n_new == '0 || {1'b0, n_new} > MAXW)
              st_d = S_ERR;
            else
              st_d = S_DATA;
          end
        end
        S_DATA: begin
          if (rx_valid) begin
            // little-endian: first byte ends up in [7:0]
            csum_d = csum_q ^ rx_data;
            word_d = {rx_data, word_q[31:8]};
            lane_d = lane_q + 2'd1;
            if (lane_q == 2'd3) begin
              req_d  = 1'b1;
              addr_d = ROM_BASE + {14'b0, cnt_q, 2'b00};
              st_d   = S_WRITE;
            end
          end
        end
        S_WRITE: begin
          if (mem.mem_gnt_i) begin
            req_d = 1'b0;
            cnt_d = cnt_q + 16'd1;
            st_d  = (cnt_q + 16'd1 == len_q) ? S_CSUM : S_DATA;
          end
        end
        S_CSUM: begin
          if (rx_valid)
            st_d = (rx_data == csum_q) ? S_DONE : S_ERR;
        end
        S_DONE, S_ERR: st_d = S_IDLE;
      endcase
    end
    if (st_d == S_ERR) begin
      err_d  = 1'b1;
      hold_d = 1'b0;
      req_d  = 1'b0;
    end
    if (st_d == S_DONE) begin
      done_d = 1'b1;
      hold_d = 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader.
// Drives framed images over UART and checks writes/status.
module tb_uart_prog_loader;

  localparam int DIV = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load_en = 1'b1;
  logic        rx = 1'b1;
  logic        gnt = 1'b1;
  logic        hold, done, err;
  logic [15:0] wcnt;

  int          n_vec = 0;
  int          n_miss = 0;
  int          req_cyc = 0;
  int          rxv_cnt = 0;
  logic [31:0] wa[$];
  logic [31:0] wd[$];
  logic [7:0]  fr[$];
  logic [31:0] a0, d0;
  bit          stable;

  always #5 clk = ~clk;

  uart_prog_loader_if mem_bus();
  assign mem_bus.mem_gnt_i = gnt;

  uart_prog_loader #(
    .CLK_FREQ  (1_600_000),
    .BAUD      (100_000),
    .ROM_BASE  (32'h0000_0000),
    .MAX_WORDS (4096)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load_en_i   (load_en),
    .uart_rx_i   (rx),
    .mem         (mem_bus),
    .core_hold_o (hold),
    .done_o      (done),
    .err_o       (err),
    .word_cnt_o  (wcnt)
  );

  always @(negedge clk) begin
    if (dut.rx_valid) rxv_cnt++;
    if (mem_bus.mem_req_o) begin
      req_cyc++;
      if (mem_bus.mem_gnt_i) begin
        wa.push_back(mem_bus.mem_addr_o);
        wd.push_back(mem_bus.mem_data_o);
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic chk_wr(input int i,
                        input logic [31:0] addr,
                        input logic [31:0] data);
    chk($sformatf("wr%0d_addr", i),
        (i < wa.size()) ? wa[i] : 32'hxxxx_xxxx, addr);
    chk($sformatf("wr%0d_data", i),
        (i < wd.size()) ? wd[i] : 32'hxxxx_xxxx, data);
  endtask

  task automatic bits(input int n);
    repeat (n * DIV) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b,
                           input bit bad_stop);
    rx = 1'b0;
    bits(1);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      bits(1);
    end
    rx = ~bad_stop;
    bits(1);
    rx = 1'b1;
    bits(1);
  endtask

  task automatic send_fr();
    foreach (fr[i]) send_byte(fr[i], 1'b0);
  endtask

  task automatic clr_log();
    wa.delete();
    wd.delete();
    req_cyc = 0;
  endtask

  task automatic settle();
    bits(1);
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_hold", hold, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_req", mem_bus.mem_req_o, 0);
    chk("rst_cnt", wcnt, 0);
    rst = 1'b1;
    bits(2);

    rx = 1'b0;
    repeat (5) @(posedge clk);
    rx = 1'b1;
    settle();
    chk("glitch_rxv", rxv_cnt, 0);
    fr = '{8'h00, 8'hFF};
    send_fr();
    settle();
    chk("noise_rxv", rxv_cnt, 2);
    chk("noise_hold", hold, 0);
    chk("noise_err", err, 0);

    // good two-word image; checksum 13^93^10 = 90
    clr_log();
    fr = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
           8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
    send_fr();
    settle();
    chk("t1_done", done, 1);
    chk("t1_err", err, 0);
    chk("t1_cnt", wcnt, 2);
    chk("t1_hold", hold, 0);
    chk("t1_nwr", wa.size(), 2);
    chk("t1_reqcyc", req_cyc, 2);
    chk_wr(0, 32'h0, 32'h0000_0013);
    chk_wr(1, 32'h4, 32'h0010_0093);

    clr_log();
    fr = '{8'hA5, 8'h02, 8'h00};
    send_fr();
    @(negedge clk);
    chk("t2_hold_mid", hold, 1);
    chk("t2_done_clr", done, 0);
    fr = '{8'h13, 8'h00, 8'h00, 8'h00,
           8'h93, 8'h00, 8'h10, 8'h00, 8'h00};
    send_fr();
    settle();
    chk("t2_err", err, 1);
    chk("t2_done", done, 0);
    chk("t2_nwr", wa.size(), 2);
    chk("t2_cnt", wcnt, 2);
    chk("t2_hold", hold, 0);

    clr_log();
    fr = '{8'hA5, 8'h00, 8'h00};
    send_fr();
    settle();
    chk("t3a_err", err, 1);
    chk("t3a_hold", hold, 0);
    fr = '{8'hA5, 8'h01, 8'h10};
    send_fr();
    settle();
    chk("t3b_err", err, 1);
    chk("t3b_done", done, 0);
    chk("t3_reqcyc", req_cyc, 0);

    clr_log();
    fr = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22};
    send_fr();
    send_byte(8'h33, 1'b1);
    settle();
    chk("t4_err", err, 1);
    chk("t4_hold", hold, 0);
    chk("t4_reqcyc", req_cyc, 0);

    gnt = 1'b0;
    clr_log();
    fr = '{8'hA5, 8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
    send_fr();
    @(negedge clk);
    a0 = mem_bus.mem_addr_o;
    d0 = mem_bus.mem_data_o;
    stable = 1'b1;
    repeat (20 * DIV) begin
      @(negedge clk);
      if (mem_bus.mem_req_o !== 1'b1 ||
          mem_bus.mem_addr_o !== a0 ||
          mem_bus.mem_data_o !== d0)
        stable = 1'b0;
    end
    chk("t5_stable", stable, 1);
    chk("t5_req", mem_bus.mem_req_o, 1);
    chk("t5_we", mem_bus.mem_we_o, 1);
    chk("t5_addr", mem_bus.mem_addr_o, 32'h0);
    chk("t5_data", mem_bus.mem_data_o, 32'h1122_3344);
    send_byte(8'h00, 1'b0);
    settle();
    chk("t5_err", err, 1);
    chk("t5_req_off", mem_bus.mem_req_o, 0);
    chk("t5_hold", hold, 0);
    chk("t5_nwr", wa.size(), 0);
    gnt = 1'b1;

    clr_log();
    fr = '{8'hA5, 8'h01, 8'h00, 8'h55, 8'h66};
    send_fr();
    load_en = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("t6a_err", err, 1);
    chk("t6a_hold", hold, 0);
    load_en = 1'b1;
    bits(1);
    fr = '{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56,
           8'h34, 8'h12, 8'h08};
    send_fr();
    settle();
    chk("t6a_done", done, 1);
    chk("t6a_err2", err, 0);
    chk("t6a_cnt", wcnt, 1);
    chk_wr(0, 32'h0, 32'h1234_5678);

    clr_log();
    fr = '{8'hA5, 8'h02, 8'h00, 8'hAA, 8'hBB};
    send_fr();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t6b_hold", hold, 0);
    chk("t6b_done", done, 0);
    chk("t6b_err", err, 0);
    chk("t6b_cnt", wcnt, 0);
    chk("t6b_req", mem_bus.mem_req_o, 0);
    rst = 1'b1;
    bits(2);
    fr = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
           8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
    send_fr();
    settle();
    chk("t6b_done2", done, 1);
    chk("t6b_cnt2", wcnt, 2);
    chk("t6b_nwr", wa.size(), 2);
    chk_wr(1, 32'h4, 32'h0010_0093);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_miss);
    $finish;
  end

endmodule
